// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the MEM-stage data memory responder.
// FSM states, request size/direction codes and word beat count.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BEAT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic SIZE_BYTE  = 1'b0;
   localparam logic SIZE_WORD  = 1'b1;
   localparam logic RW_READ    = 1'b0;
   localparam logic RW_WRITE   = 1'b1;
   localparam int   WORD_BEATS = 4;

endpackage

// File: rtl/data_mem_responder_bytes.sv
// Byte-wide storage array for the data memory responder.
// One synchronous write port, one combinational read port.
module data_mem_responder_bytes #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [7:0]        i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [7:0]        o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0] Mem [DEPTH];

   // synchronous byte write, storage is never cleared
   always_ff @(posedge clk) begin
      if (i_we) begin
         Mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = Mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: byte/word big-endian loads and stores,
// one byte per cycle, combinational stall, registered response.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_en,
   input  logic        req_rw,
   input  logic        req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata
);

   state_t            r_state;
   logic [1:0]        r_beat;
   logic              r_rw;
   logic              r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_ldata;

   logic              w_acc;
   logic              w_act;
   logic              w_rw;
   logic              w_size;
   logic              w_we;
   logic [ADDR_W-1:0] w_req_addr;
   logic [ADDR_W-1:0] w_maddr;
   logic [31:0]       w_wsrc;
   logic [4:0]        w_shift;
   logic [7:0]        w_wbyte;
   logic [7:0]        w_rbyte;
   logic              w_unused;

   assign w_unused = &{1'b0, req_addr[31:ADDR_W]};

   // beat 0 is served on the accepting edge straight from the inputs
   assign w_acc = (r_state == ST_IDLE) & req_en;
   assign w_act = w_acc | (r_state == ST_BEAT);
   assign w_rw   = w_acc ? req_rw    : r_rw;
   assign w_size = w_acc ? req_size  : r_size;
   assign w_wsrc = w_acc ? req_wdata : r_wdata;

   assign w_req_addr = (req_size == SIZE_WORD)
                     ? {req_addr[ADDR_W-1:2], 2'b00}
                     : req_addr[ADDR_W-1:0];

   assign w_maddr = w_acc ? w_req_addr
                          : r_addr + ADDR_W'(r_beat);

   // big-endian lane: beat k maps to bits [31-8k -: 8]
   assign w_shift = (w_size == SIZE_WORD)
                  ? 5'd24 - {r_beat, 3'b000}
                  : 5'd0;

   assign w_wbyte = 8'(w_wsrc >> w_shift);
   assign w_we    = reset & w_act & (w_rw == RW_WRITE);

   assign stall = (r_state == ST_BEAT) | w_acc;

   data_mem_responder_bytes #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_maddr),
      .i_wdata (w_wbyte),
      .i_raddr (w_maddr),
      .o_rdata (w_rbyte)
   );

   // request FSM: latch on accept, step beats, pulse response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_beat    <= 2'd0;
         r_rw      <= RW_READ;
         r_size    <= SIZE_BYTE;
         r_addr    <= '0;
         r_wdata   <= 32'h0;
         r_ldata   <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (req_en) begin
                  r_rw    <= req_rw;
                  r_size  <= req_size;
                  r_addr  <= w_req_addr;
                  r_wdata <= req_wdata;
                  r_ldata <= {w_rbyte, 24'h0};
                  if (req_size == SIZE_WORD) begin
                     r_state <= ST_BEAT;
                     r_beat  <= 2'd1;
                  end else begin
                     r_state   <= ST_RESP;
                     rsp_valid <= 1'b1;
                     if (req_rw == RW_READ) begin
                        rsp_rdata <= {24'h0, w_rbyte};
                     end
                  end
               end
            end
            ST_BEAT: begin
               r_ldata <= r_ldata | ({24'h0, w_rbyte} << w_shift);
               if (r_beat == 2'(WORD_BEATS - 1)) begin
                  r_state   <= ST_RESP;
                  r_beat    <= 2'd0;
                  rsp_valid <= 1'b1;
                  if (r_rw == RW_READ) begin
                     rsp_rdata <= {r_ldata[31:8], w_rbyte};
                  end
               end else begin
                  r_beat <= r_beat + 2'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
